// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master
// Purpose  : Single-outstanding AXI4-Lite master driven by a valid/ready
//            command port; returns read data / response code on a response
//            port, with an optional hung-slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // AW channel
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [2:0]              write_prot,
  output logic                    write_addr_valid,
  input  logic                    write_addr_ready,
  // W channel
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    write_data_valid,
  input  logic                    write_data_ready,
  // B channel
  input  logic [1:0]              write_resp,
  input  logic                    write_resp_valid,
  output logic                    write_resp_ready,
  // AR channel
  output logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [2:0]              read_prot,
  output logic                    read_addr_valid,
  input  logic                    read_addr_ready,
  // R channel
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic [1:0]              read_resp,
  input  logic                    read_data_valid,
  output logic                    read_data_ready
);

  // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  // The count reaches TIMEOUT_CYCLES on the edge that ends the cycle where it equals TO_LAST.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done, w_done;
  logic [CNT_W-1:0]        tcount;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    timeout_q;

  logic accept, busy, expire;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Valids/readies are pure state decodes, so no AXI input reaches an AXI output.
  assign cmd_ready        = (state == IDLE);
  assign write_addr_valid = (state == WR_REQ) && !aw_done;
  assign write_data_valid = (state == WR_REQ) && !w_done;
  assign write_resp_ready = (state == WR_RESP);
  assign read_addr_valid  = (state == RD_REQ);
  assign read_data_ready  = (state == RD_DATA);
  assign rsp_valid        = (state == RESP);

  assign write_addr  = addr_q;
  assign read_addr   = addr_q;
  assign write_data  = wdata_q;
  assign write_strb  = wstrb_q;
  assign write_prot  = 3'b000;
  assign read_prot   = 3'b000;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = write_addr_valid && write_addr_ready;
  assign w_hs   = write_data_valid && write_data_ready;
  assign b_hs   = write_resp_ready && write_resp_valid;
  assign ar_hs  = read_addr_valid  && read_addr_ready;
  assign r_hs   = read_data_ready  && read_data_valid;
  assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_DATA);
  assign expire = TO_EN && busy && (tcount == TO_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode; a final B/R handshake beats a coincident timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  begin
        if (expire)                                     next_state = RESP;
        else if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = WR_RESP;
      end
      WR_RESP: if (b_hs || expire) next_state = RESP;
      RD_REQ:  begin
        if (expire)     next_state = RESP;
        else if (ar_hs) next_state = RD_DATA;
      end
      RD_DATA: if (r_hs || expire) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch, handshake tracking, timeout counter and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      tcount    <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else if (accept) begin
      addr_q    <= cmd_addr;
      wdata_q   <= cmd_wdata;
      wstrb_q   <= cmd_wstrb;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      tcount    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (busy) tcount <= tcount + CNT_W'(1);
      if (state == WR_REQ) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done  || w_hs;
      end
      if (b_hs) begin
        resp_q  <= write_resp;
        rdata_q <= '0;
      end else if (r_hs) begin
        resp_q  <= read_resp;
        rdata_q <= read_data;
      end else if (expire) begin
        resp_q    <= 2'b10;
        rdata_q   <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master
// Purpose  : Self-checking bench for axi_lite_master with a delay-configurable
//            slave and a transaction-level latency/response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] write_addr, write_data, read_addr;
  logic [2:0]  write_prot, read_prot;
  logic [3:0]  write_strb;
  logic        write_addr_valid, write_addr_ready, write_data_valid, write_data_ready;
  logic        write_resp_valid, write_resp_ready, read_addr_valid, read_addr_ready;
  logic        read_data_valid, read_data_ready;
  logic [1:0]  write_resp, read_resp;
  logic [31:0] read_data;

  // Slave configuration (written by the main sequence only).
  int d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
  bit hang_aw = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;

  // Slave wait counters and bus monitor counters.
  int cnt_aw = 0, cnt_w = 0, cnt_b = 0, cnt_ar = 0, cnt_r = 0;
  int n_awv = 0, n_wv = 0, n_arv = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  int checks = 0;
  int errors = 0;

  assign write_addr_ready = write_addr_valid && !hang_aw && (cnt_aw >= d_aw);
  assign write_data_ready = write_data_valid && (cnt_w >= d_w);
  assign write_resp_valid = write_resp_ready && (cnt_b >= d_b);
  assign read_addr_ready  = read_addr_valid && (cnt_ar >= d_ar);
  assign read_data_valid  = read_data_ready && (cnt_r >= d_r);
  assign write_resp       = s_bresp;
  assign read_data        = s_rdata;
  assign read_resp        = s_rresp;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .write_addr(write_addr), .write_prot(write_prot),
    .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
    .write_data(write_data), .write_strb(write_strb),
    .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_resp(write_resp), .write_resp_valid(write_resp_valid),
    .write_resp_ready(write_resp_ready),
    .read_addr(read_addr), .read_prot(read_prot),
    .read_addr_valid(read_addr_valid), .read_addr_ready(read_addr_ready),
    .read_data(read_data), .read_resp(read_resp),
    .read_data_valid(read_data_valid), .read_data_ready(read_data_ready)
  );

  // Slave wait-state counters and per-channel valid/handshake tallies.
  always @(posedge clk) begin
    cnt_aw <= (write_addr_valid && !write_addr_ready) ? cnt_aw + 1 : 0;
    cnt_w  <= (write_data_valid && !write_data_ready) ? cnt_w + 1 : 0;
    cnt_b  <= (write_resp_ready && !write_resp_valid) ? cnt_b + 1 : 0;
    cnt_ar <= (read_addr_valid && !read_addr_ready) ? cnt_ar + 1 : 0;
    cnt_r  <= (read_data_ready && !read_data_valid) ? cnt_r + 1 : 0;
    if (write_addr_valid) n_awv <= n_awv + 1;
    if (write_data_valid) n_wv  <= n_wv + 1;
    if (read_addr_valid)  n_arv <= n_arv + 1;
    if (write_addr_valid && write_addr_ready) n_aw <= n_aw + 1;
    if (write_data_valid && write_data_ready) n_w  <= n_w + 1;
    if (write_resp_valid && write_resp_ready) n_b  <= n_b + 1;
    if (read_addr_valid && read_addr_ready)   n_ar <= n_ar + 1;
    if (read_data_valid && read_data_ready)   n_r  <= n_r + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end; expectations come from the slave delays alone.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int bp);
    int f, exp_lat, k;
    bit exp_to;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int s_awv, s_wv, s_arv, s_aw, s_w, s_b, s_ar, s_r;
    if (wr) f = hang_aw ? 1000 : 2 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
    else    f = 2 + d_ar + d_r;
    exp_to    = (f > T);
    exp_lat   = exp_to ? T + 1 : f + 1;
    exp_rdata = (wr || exp_to) ? 32'h0 : s_rdata;
    exp_resp  = exp_to ? 2'b10 : (wr ? s_bresp : s_rresp);
    s_awv = n_awv; s_wv = n_wv; s_arv = n_arv;
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = st;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    check("req_valids", {write_addr_valid, write_data_valid, read_addr_valid},
          wr ? 3'b110 : 3'b001);
    check("cmd_ready_busy", cmd_ready, 1'b0);
    check("axi_addr", wr ? write_addr : read_addr, a);
    if (wr) check("axi_wdata_strb", {write_data, write_strb}, {wd, st});
    while (!rsp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("rsp_latency", k, exp_lat);
    check("rsp_fields", {rsp_timeout, rsp_resp, rsp_rdata}, {exp_to, exp_resp, exp_rdata});
    check("axi_idle_in_resp",
          {write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid, read_data_ready},
          5'b0);
    if (wr && !exp_to) begin
      check("wr_hs_counts", {n_aw - s_aw, n_w - s_w, n_b - s_b}, {32'd1, 32'd1, 32'd1});
      check("wr_valid_cycles", {n_awv - s_awv, n_wv - s_wv}, {d_aw + 1, d_w + 1});
    end else if (!wr && !exp_to) begin
      check("rd_hs_counts", {n_ar - s_ar, n_r - s_r}, {32'd1, 32'd1});
      check("rd_valid_cycles", n_arv - s_arv, d_ar + 1);
    end else begin
      check("to_no_final_hs", wr ? (n_b - s_b) : (n_r - s_r), 0);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata},
            {1'b1, 1'b0, exp_to, exp_resp, exp_rdata});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("back_to_idle", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_outputs",
          {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, write_addr_valid, write_data_valid,
           write_resp_ready, read_addr_valid, read_data_ready, write_prot, read_prot},
          '0);
    check("reset_addr_data", {write_addr, write_data, write_strb}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1'b1);

    // Always-ready slave write.
    run_txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0);

    // Write skew: W ready three cycles before AW ready.
    d_aw = 3; d_w = 0; s_bresp = 2'b01;
    run_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 0);

    // Read with 5 wait cycles and SLVERR, plus 4 cycles of response backpressure.
    d_aw = 0; d_ar = 0; d_r = 5; s_rdata = 32'h1234_5678; s_rresp = 2'b10;
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 4);
    // Issued the cycle after release.
    d_r = 0; s_rdata = 32'hA5A5_0001; s_rresp = 2'b00;
    run_txn(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0);

    // B handshake on the last cycle before timeout wins; one cycle later times out.
    d_b = 14; s_bresp = 2'b00;
    run_txn(1'b1, 32'h0000_0020, 32'h1111_2222, 4'h3, 0);
    d_b = 15;
    run_txn(1'b1, 32'h0000_0024, 32'h3333_4444, 4'hC, 1);

    // Slave never accepts AW.
    d_b = 0; hang_aw = 1'b1;
    run_txn(1'b1, 32'h0000_0028, 32'h5555_6666, 4'hF, 0);
    hang_aw = 1'b0;

    // Reset while waiting in RD_DATA.
    d_ar = 0; d_r = 10; s_rdata = 32'hBAD0_BAD0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rd_data_ready_before_rst", read_data_ready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {read_data_ready, rsp_valid, read_addr_valid, read_addr}, '0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1'b1);
    d_r = 1; s_rdata = 32'h0BAD_F00D; s_rresp = 2'b01;
    run_txn(1'b0, 32'h0000_0034, 32'h0, 4'h0, 0);

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      d_aw = $urandom_range(0, 4); d_w = $urandom_range(0, 4); d_b = $urandom_range(0, 4);
      d_ar = $urandom_range(0, 4); d_r = $urandom_range(0, 4);
      s_rdata = $urandom; s_bresp = 2'($urandom_range(0, 3)); s_rresp = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
